// File: rtl/servo_ramp_cmd.sv
// Servo command stage: clamps targets, slews pulse_ticks by <= STEP_TICKS per frame, reports done after settling.
// Width updates land on frame_end (visible from next frame_start); cmd_ready is high only while IDLE, so commands are never queued.
module servo_ramp_cmd #(
  parameter int FRAME_TICKS   = 1000,
  parameter int MIN_TICKS     = 25,
  parameter int MAX_TICKS     = 125,
  parameter int INIT_TICKS    = 35,
  parameter int STEP_TICKS    = 2,
  parameter int SETTLE_FRAMES = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_ticks,
  input  logic        enable,
  output logic [15:0] pulse_ticks,
  output logic        frame_start,
  output logic        busy,
  output logic        done,
  output logic        clamped
);

  localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int SW = $clog2(SETTLE_FRAMES + 1);

  localparam logic [15:0]   MIN_W  = 16'(MIN_TICKS);
  localparam logic [15:0]   MAX_W  = 16'(MAX_TICKS);
  localparam logic [15:0]   INIT_W = 16'(INIT_TICKS);
  localparam logic [15:0]   STEP_W = 16'(STEP_TICKS);
  localparam logic [CW-1:0] LAST_F = CW'(FRAME_TICKS - 1);
  localparam logic [SW-1:0] SET_N  = SW'(SETTLE_FRAMES);

  typedef enum logic [1:0] {IDLE, RAMP, SETTLE} state_t;

  state_t        state;
  logic [CW-1:0] frame_cnt;
  logic [15:0]   target;
  logic [SW-1:0] settle_cnt;
  logic [SW-1:0] settle_nxt;
  logic          frame_end;
  logic          accept;
  logic          too_low;
  logic          too_high;
  logic [15:0]   clamp_val;
  logic [15:0]   next_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (frame_end) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + CW'(1);
    end
  end

  assign frame_start = (frame_cnt == '0);
  assign frame_end   = (frame_cnt == LAST_F);
  assign accept      = cmd_valid && cmd_ready;
  assign too_low     = (cmd_ticks < MIN_W);
  assign too_high    = (cmd_ticks > MAX_W);
  assign settle_nxt  = settle_cnt + SW'(1);

  always_comb begin
    clamp_val = cmd_ticks;
    if (too_low) begin
      clamp_val = MIN_W;
    end else if (too_high) begin
      clamp_val = MAX_W;
    end
  end

  // Compare before subtracting so the distance never wraps; the last step may be shorter than STEP_W.
  always_comb begin
    next_pulse = pulse_ticks;
    if (target > pulse_ticks) begin
      if ((target - pulse_ticks) > STEP_W) begin
        next_pulse = pulse_ticks + STEP_W;
      end else begin
        next_pulse = target;
      end
    end else if (target < pulse_ticks) begin
      if ((pulse_ticks - target) > STEP_W) begin
        next_pulse = pulse_ticks - STEP_W;
      end else begin
        next_pulse = target;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pulse_ticks <= INIT_W;
      target      <= INIT_W;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      clamped     <= 1'b0;
      settle_cnt  <= '0;
    end else begin
      done    <= 1'b0;
      clamped <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            target    <= clamp_val;
            clamped   <= too_low || too_high;
            state     <= RAMP;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RAMP: begin
          if (frame_end && enable) begin
            // Arrival is confirmed one frame after the final step, never on the step itself.
            if (pulse_ticks == target) begin
              state      <= SETTLE;
              settle_cnt <= '0;
            end else begin
              pulse_ticks <= next_pulse;
            end
          end
        end
        SETTLE: begin
          if (frame_end && enable) begin
            if (settle_nxt == SET_N) begin
              settle_cnt <= '0;
              done       <= 1'b1;
              state      <= IDLE;
              cmd_ready  <= 1'b1;
              busy       <= 1'b0;
            end else begin
              settle_cnt <= settle_nxt;
            end
          end
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_ramp_cmd.sv
// Directed bench for servo_ramp_cmd with a short frame so every scenario fits in a few thousand cycles.
module tb_servo_ramp_cmd;

  localparam int FRAME = 40;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_ticks;
  logic        enable;
  logic [15:0] pulse_ticks;
  logic        frame_start;
  logic        busy;
  logic        done;
  logic        clamped;

  int n_checks;
  int n_fails;

  servo_ramp_cmd #(
    .FRAME_TICKS  (FRAME),
    .MIN_TICKS    (25),
    .MAX_TICKS    (125),
    .INIT_TICKS   (35),
    .STEP_TICKS   (2),
    .SETTLE_FRAMES(10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ticks  (cmd_ticks),
    .enable     (enable),
    .pulse_ticks(pulse_ticks),
    .frame_start(frame_start),
    .busy       (busy),
    .done       (done),
    .clamped    (clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Step to the next frame_start, counting done pulses and any width change seen mid-frame.
  task automatic next_frame(output logic [15:0] p, output int dn);
    logic [15:0] prev;
    int          mid;
    bit          got;
    prev = pulse_ticks;
    mid  = 0;
    dn   = 0;
    got  = 0;
    for (int i = 0; i < FRAME + 4 && !got; i++) begin
      @(negedge clk);
      if (done) dn++;
      if (frame_start) got = 1;
      else if (pulse_ticks != prev) mid++;
    end
    check_eq("frame_seen", 32'(got), 32'd1);
    check_eq("midframe_hold", 32'(mid), 32'd0);
    p = pulse_ticks;
  endtask

  task automatic send_cmd(input logic [15:0] v, input logic exp_clamp);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ticks = v;
    check_eq("ready_before_cmd", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("clamped_pulse", 32'(clamped), 32'(exp_clamp));
    check_eq("busy_after_accept", 32'(busy), 32'd1);
    check_eq("ready_after_accept", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check_eq("clamped_one_cycle", 32'(clamped), 32'd0);
  endtask

  task automatic expect_ramp(input logic [15:0] w);
    logic [15:0] p;
    int          dn;
    next_frame(p, dn);
    check_eq("ramp_width", 32'(p), 32'(w));
    check_eq("ramp_no_done", 32'(dn), 32'd0);
  endtask

  // First frame enters SETTLE, done must arrive exactly on frame nfr.
  task automatic expect_settle(input int nfr, input logic [15:0] w);
    logic [15:0] p;
    int          dn;
    for (int k = 1; k <= nfr; k++) begin
      next_frame(p, dn);
      check_eq("settle_width", 32'(p), 32'(w));
      check_eq("settle_done_count", 32'(dn), (k == nfr) ? 32'd1 : 32'd0);
    end
    check_eq("idle_ready", 32'(cmd_ready), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_to(input logic [15:0] v, input logic exp_clamp, input logic [15:0] w);
    logic [15:0] p;
    int          dn;
    int          k;
    send_cmd(v, exp_clamp);
    dn = 0;
    k  = 0;
    while (dn == 0 && k < 200) begin
      next_frame(p, dn);
      k++;
    end
    check_eq("run_done", 32'(dn), 32'd1);
    check_eq("run_final_width", 32'(pulse_ticks), 32'(w));
  endtask

  initial begin
    logic [15:0] p;
    int          dn;
    int          n;
    int          total;

    n_checks  = 0;
    n_fails   = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_ticks = '0;
    enable    = 1'b1;

    // Reset state and frame period
    repeat (3) @(negedge clk);
    check_eq("rst_pulse", 32'(pulse_ticks), 32'd35);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_clamped", 32'(clamped), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("first_frame_start", 32'(frame_start), 32'd1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < FRAME + 5);
    check_eq("frame_period", 32'(n), 32'(FRAME));

    // Ramp up 35 -> 45
    send_cmd(16'd45, 1'b0);
    expect_ramp(16'd37);
    expect_ramp(16'd39);
    expect_ramp(16'd41);
    expect_ramp(16'd43);
    expect_ramp(16'd45);
    expect_settle(11, 16'd45);

    // Clamp high with an odd final step
    run_to(16'd120, 1'b0, 16'd120);
    send_cmd(16'd200, 1'b1);
    expect_ramp(16'd122);
    expect_ramp(16'd124);
    expect_ramp(16'd125);
    expect_settle(11, 16'd125);

    // Clamp low
    run_to(16'd0, 1'b1, 16'd25);

    // Same target: settle entry at the first frame_end
    send_cmd(16'd25, 1'b0);
    expect_settle(11, 16'd25);

    // Freeze during ramp
    send_cmd(16'd35, 1'b0);
    expect_ramp(16'd27);
    expect_ramp(16'd29);
    enable = 1'b0;
    for (int k = 0; k < 3; k++) expect_ramp(16'd29);
    check_eq("freeze_busy", 32'(busy), 32'd1);
    enable = 1'b1;
    expect_ramp(16'd31);
    expect_ramp(16'd33);
    expect_ramp(16'd35);
    expect_ramp(16'd35);
    for (int k = 0; k < 3; k++) expect_ramp(16'd35);

    // Freeze during settle with a command held pending
    enable    = 1'b0;
    cmd_valid = 1'b1;
    cmd_ticks = 16'd40;
    #1;
    check_eq("busy_not_ready", 32'(cmd_ready), 32'd0);
    for (int k = 0; k < 3; k++) expect_ramp(16'd35);
    check_eq("held_not_accepted", 32'(cmd_ready), 32'd0);
    enable = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      next_frame(p, dn);
      check_eq("settle_resume_done", 32'(dn), (k == 7) ? 32'd1 : 32'd0);
    end
    check_eq("ready_at_done", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check_eq("pending_accepted_busy", 32'(busy), 32'd1);
    check_eq("pending_accepted_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b0;
    expect_ramp(16'd37);
    expect_ramp(16'd39);

    // Reset mid-ramp
    rst = 1'b1;
    #1;
    check_eq("midrst_pulse", 32'(pulse_ticks), 32'd35);
    check_eq("midrst_ready", 32'(cmd_ready), 32'd1);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_frame_start", 32'(frame_start), 32'd1);
    @(negedge clk);
    rst   = 1'b0;
    total = 0;
    for (int k = 0; k < 12; k++) begin
      next_frame(p, dn);
      total += dn;
    end
    check_eq("midrst_no_done", 32'(total), 32'd0);
    check_eq("midrst_width_hold", 32'(pulse_ticks), 32'd35);
    check_eq("midrst_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
